// File: rtl/fig_04b_pkg.sv
// Shared opcode, lane and mode definitions for the GSU register-file sequencer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package fig_04b_pkg;

  // Prefix opcodes: full-byte ALT forms, high-nibble TO/WITH/FROM forms
  localparam logic [7:0] OP_ALT1    = 8'h3D;
  localparam logic [7:0] OP_ALT2    = 8'h3E;
  localparam logic [7:0] OP_ALT3    = 8'h3F;
  localparam logic [3:0] OP_TO_HI   = 4'h1;
  localparam logic [3:0] OP_WITH_HI = 4'h2;
  localparam logic [3:0] OP_FROM_HI = 4'hB;

  // Write-lane encoding from the main decoder
  localparam logic [1:0] LANE_W = 2'b11;
  localparam logic [1:0] LANE_L = 2'b01;
  localparam logic [1:0] LANE_H = 2'b10;

  // NORM: no prefix pending; PFX: at least one prefix accumulated
  typedef enum logic [0:0] {
    NORM = 1'b0,
    PFX  = 1'b1
  } mode_t;

endpackage

// File: rtl/fig_04b_block_077_wb_stage.sv
// Registered destination select / write strobe / fromset stage.
// Latency: 1 cycle from i_vld to strobe; zsel holds between writes.
// Backpressure: none; a captured write always fires the next cycle.
module fig_04b_block_077_wb_stage #(
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_vld,
  input  logic [SW-1:0] i_zsel,
  input  logic          i_en,
  input  logic          i_en_l,
  input  logic          i_en_h,
  input  logic          i_from,
  output logic [SW-1:0] o_zsel,
  output logic          o_en,
  output logic          o_en_l,
  output logic          o_en_h,
  output logic          o_from
);

  logic [SW-1:0] r_zsel;
  logic          r_en;
  logic          r_en_l;
  logic          r_en_h;
  logic          r_from;

  // Capture the write on a non-prefix accept; strobes are single-cycle pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_zsel <= '0;
      r_en   <= 1'b0;
      r_en_l <= 1'b0;
      r_en_h <= 1'b0;
      r_from <= 1'b0;
    end else begin
      r_en   <= i_vld & i_en;
      r_en_l <= i_vld & i_en_l;
      r_en_h <= i_vld & i_en_h;
      r_from <= i_vld & i_from;
      if (i_vld) begin
        r_zsel <= i_zsel;
      end
    end
  end

  assign o_zsel = r_zsel;
  assign o_en   = r_en;
  assign o_en_l = r_en_l;
  assign o_en_h = r_en_h;
  assign o_from = r_from;

endmodule

// File: rtl/fig_04b_block_077_reg_prefix_seq.sv
// GSU register-file select/write sequencer tracking ALT/TO/FROM/WITH prefixes.
// Latency: xsel/ysel combinational in the accept cycle; write strobe 1 cycle after accept.
// Backpressure: hold freezes prefix state and drops op_ready; pending strobes still fire.
module fig_04b_block_077_reg_prefix_seq
  import fig_04b_pkg::*;
#(
  parameter int NREG    = 16,
  parameter int DEF_REG = 0,
  localparam int SW     = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [7:0]    op,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic          hold,
  input  logic          wr_req,
  input  logic [1:0]    wr_lane,
  output logic [SW-1:0] xsel,
  output logic [SW-1:0] ysel,
  output logic [SW-1:0] zsel,
  output logic          enable,
  output logic          enable_l,
  output logic          enable_h,
  output logic          fromset,
  output logic [1:0]    alt,
  output logic          b_flag
);

  localparam logic [SW-1:0] DEF_SEL = SW'(DEF_REG);

  logic [SW-1:0] r_sreg, r_dreg;
  logic          r_b;
  logic [1:0]    r_alt;
  mode_t         r_mode;

  logic [SW-1:0] w_sreg_nxt, w_dreg_nxt;
  logic          w_b_nxt;
  logic [1:0]    w_alt_nxt;
  mode_t         w_mode_nxt;

  logic          w_accept;
  logic [3:0]    w_hi;
  logic [SW-1:0] w_n;
  logic          w_is_alt, w_is_with, w_is_to, w_is_from, w_is_move, w_is_moves;

  logic          w_wb_vld, w_wb_en, w_wb_en_l, w_wb_en_h, w_wb_from;
  logic [SW-1:0] w_wb_zsel;

  assign w_accept = op_valid & ~hold;
  assign w_hi     = op[7:4];
  assign w_n      = SW'(op[3:0]);

  // 0x1n / 0xBn are prefixes only while B is clear; with B set they become moves
  assign w_is_alt   = (op == OP_ALT1) | (op == OP_ALT2) | (op == OP_ALT3);
  assign w_is_with  = (w_hi == OP_WITH_HI);
  assign w_is_to    = (w_hi == OP_TO_HI)   & ~r_b;
  assign w_is_from  = (w_hi == OP_FROM_HI) & ~r_b;
  assign w_is_move  = (w_hi == OP_TO_HI)   &  r_b;
  assign w_is_moves = (w_hi == OP_FROM_HI) &  r_b;

  // Prefix state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sreg <= DEF_SEL;
      r_dreg <= DEF_SEL;
      r_b    <= 1'b0;
      r_alt  <= 2'd0;
      r_mode <= NORM;
    end else begin
      r_sreg <= w_sreg_nxt;
      r_dreg <= w_dreg_nxt;
      r_b    <= w_b_nxt;
      r_alt  <= w_alt_nxt;
      r_mode <= w_mode_nxt;
    end
  end

  // Next prefix state and the write to hand to the writeback stage
  always_comb begin
    w_sreg_nxt = r_sreg;
    w_dreg_nxt = r_dreg;
    w_b_nxt    = r_b;
    w_alt_nxt  = r_alt;
    w_mode_nxt = r_mode;
    w_wb_vld   = 1'b0;
    w_wb_zsel  = r_dreg;
    w_wb_en    = 1'b0;
    w_wb_en_l  = 1'b0;
    w_wb_en_h  = 1'b0;
    w_wb_from  = 1'b0;
    if (w_accept) begin
      if (w_is_alt) begin
        w_alt_nxt  = op[1:0];
        w_mode_nxt = PFX;
      end else if (w_is_with) begin
        w_sreg_nxt = w_n;
        w_dreg_nxt = w_n;
        w_b_nxt    = 1'b1;
        w_mode_nxt = PFX;
      end else if (w_is_to) begin
        w_dreg_nxt = w_n;
        w_mode_nxt = PFX;
      end else if (w_is_from) begin
        w_sreg_nxt = w_n;
        w_mode_nxt = PFX;
      end else begin
        // Non-prefix (including MOVE/MOVES): issue write, drop all prefix state
        w_wb_vld   = 1'b1;
        w_sreg_nxt = DEF_SEL;
        w_dreg_nxt = DEF_SEL;
        w_b_nxt    = 1'b0;
        w_alt_nxt  = 2'd0;
        w_mode_nxt = NORM;
        if (w_is_move | w_is_moves) begin
          w_wb_zsel = w_is_move ? w_n : r_dreg;
          w_wb_en   = 1'b1;
          w_wb_from = w_is_move;
        end else begin
          w_wb_en   = wr_req & (wr_lane == LANE_W);
          w_wb_en_l = wr_req & (wr_lane == LANE_L);
          w_wb_en_h = wr_req & (wr_lane == LANE_H);
        end
      end
    end
  end

  fig_04b_block_077_wb_stage #(.SW(SW)) u_wb (
    .clk     (clk),
    .reset_n (reset_n),
    .i_vld   (w_wb_vld),
    .i_zsel  (w_wb_zsel),
    .i_en    (w_wb_en),
    .i_en_l  (w_wb_en_l),
    .i_en_h  (w_wb_en_h),
    .i_from  (w_wb_from),
    .o_zsel  (zsel),
    .o_en    (enable),
    .o_en_l  (enable_l),
    .o_en_h  (enable_h),
    .o_from  (fromset)
  );

  assign op_ready = ~hold;
  assign xsel     = r_sreg;
  assign ysel     = (w_accept & w_is_moves) ? w_n : r_sreg;
  assign alt      = r_alt;
  assign b_flag   = r_b;

endmodule

// File: tb/tb_fig_04b_block_077_reg_prefix_seq.sv
// Scoreboard bench for the GSU prefix sequencer.
// Latency: expects strobes exactly one cycle after each non-prefix accept.
// Backpressure: exercises hold with op_valid held high.
module tb_fig_04b_block_077_reg_prefix_seq;

  logic       clk;
  logic       reset_n;
  logic [7:0] op;
  logic       op_valid;
  logic       op_ready;
  logic       hold;
  logic       wr_req;
  logic [1:0] wr_lane;
  logic [3:0] xsel, ysel, zsel;
  logic       enable, enable_l, enable_h, fromset;
  logic [1:0] alt;
  logic       b_flag;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         due;
    logic [3:0] z;
    logic       e, el, eh, fr;
  } wb_exp_t;
  wb_exp_t sb[$];

  fig_04b_block_077_reg_prefix_seq dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .op       (op),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .hold     (hold),
    .wr_req   (wr_req),
    .wr_lane  (wr_lane),
    .xsel     (xsel),
    .ysel     (ysel),
    .zsel     (zsel),
    .enable   (enable),
    .enable_l (enable_l),
    .enable_h (enable_h),
    .fromset  (fromset),
    .alt      (alt),
    .b_flag   (b_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  // Cycle counter plus writeback monitor, sampled 1 time unit after each edge
  always @(posedge clk) begin
    wb_exp_t it;
    cyc = cyc + 1;
    #1;
    if (reset_n) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        it = sb.pop_front();
        total++; bad++;
        $display("FAIL wb_missed: got no check at cycle %0d want write due %0d", cyc, it.due);
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        it = sb.pop_front();
        total++;
        if ({zsel, enable, enable_l, enable_h, fromset} !== {it.z, it.e, it.el, it.eh, it.fr}) begin
          bad++;
          $display("FAIL wb_write: got z=%0d e=%b l=%b h=%b f=%b want z=%0d e=%b l=%b h=%b f=%b",
                   zsel, enable, enable_l, enable_h, fromset, it.z, it.e, it.el, it.eh, it.fr);
        end
      end else begin
        total++;
        if ({enable, enable_l, enable_h, fromset} !== 4'b0000) begin
          bad++;
          $display("FAIL wb_idle: got e=%b l=%b h=%b f=%b want all 0 at cycle %0d",
                   enable, enable_l, enable_h, fromset, cyc);
        end
      end
    end
  end

  // Present one op at the negedge; non-prefix ops push their expected write
  task automatic send(input logic [7:0] o, input logic wr, input logic [1:0] ln, input logic np,
                      input logic [3:0] ez, input logic ee, input logic eel, input logic eeh,
                      input logic efr);
    wb_exp_t it;
    @(negedge clk);
    op = o; op_valid = 1'b1; hold = 1'b0; wr_req = wr; wr_lane = ln;
    if (np) begin
      it.due = cyc + 1; it.z = ez; it.e = ee; it.el = eel; it.eh = eeh; it.fr = efr;
      sb.push_back(it);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    op_valid = 1'b0; hold = 1'b0; wr_req = 1'b0; wr_lane = 2'b00; op = 8'h00;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; op = 8'h00; op_valid = 1'b0; hold = 1'b0; wr_req = 1'b0; wr_lane = 2'b00;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({zsel, enable, enable_l, enable_h, fromset} !== 8'h00) begin
      bad++; $display("FAIL reset_wb: got %h want 00", {zsel, enable, enable_l, enable_h, fromset});
    end
    total++;
    if ({alt, b_flag, xsel, ysel} !== 11'h000) begin
      bad++; $display("FAIL reset_state: got alt=%0d b=%b x=%0d y=%0d want 0", alt, b_flag, xsel, ysel);
    end
    total++;
    if (op_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", op_ready); end
    @(negedge clk); reset_n = 1'b1;
    // Reset with a write presented but not yet accepted: nothing must fire
    send(8'h3E, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    send(8'h21, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    send(8'h50, 1, 2'b11, 1, 4'd1, 1, 0, 0, 0);
    #1;
    total++;
    if ({alt, b_flag, xsel} !== {2'd2, 1'b1, 4'd1}) begin
      bad++; $display("FAIL pre_reset_state: got alt=%0d b=%b x=%0d want 2 1 1", alt, b_flag, xsel);
    end
    #1; reset_n = 1'b0; sb.delete();
    #1;
    total++;
    if ({alt, b_flag, xsel, enable} !== 8'h00) begin
      bad++; $display("FAIL midreset_state: got alt=%0d b=%b x=%0d e=%b want 0", alt, b_flag, xsel, enable);
    end
    @(posedge clk); #1;
    total++;
    if ({zsel, enable, enable_l, enable_h} !== 7'h00) begin
      bad++; $display("FAIL midreset_cancel: got z=%0d e=%b want 0 0", zsel, enable);
    end
    @(negedge clk); op_valid = 1'b0; reset_n = 1'b1;
    // Reset while a strobe is already high clears it in the same cycle
    send(8'h2A, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    send(8'h50, 1, 2'b11, 1, 4'd10, 1, 0, 0, 0);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    total++;
    if ({zsel, enable, enable_l, enable_h, fromset} !== 8'h00) begin
      bad++; $display("FAIL reset_strobe: got z=%0d e=%b want 0 0", zsel, enable);
    end
    @(negedge clk); op_valid = 1'b0; reset_n = 1'b1;
  endtask

  task automatic test_to_from();
    send(8'h13, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    send(8'hB5, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    send(8'h50, 1, 2'b11, 1, 4'd3, 1, 0, 0, 0);
    #1;
    total++;
    if (xsel !== 4'd5 || ysel !== 4'd5) begin
      bad++; $display("FAIL to_from_sel: got x=%0d y=%0d want 5 5", xsel, ysel);
    end
    idle(); #1;
    total++;
    if (xsel !== 4'd0) begin bad++; $display("FAIL to_from_clear: got x=%0d want 0", xsel); end
  endtask

  task automatic test_move();
    send(8'h27, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    send(8'h14, 0, 2'b00, 1, 4'd4, 1, 0, 0, 1);
    #1;
    total++;
    if (ysel !== 4'd7 || b_flag !== 1'b1) begin
      bad++; $display("FAIL move_ysel: got y=%0d b=%b want 7 1", ysel, b_flag);
    end
    idle(); #1;
    total++;
    if (b_flag !== 1'b0 || xsel !== 4'd0) begin
      bad++; $display("FAIL move_clear: got b=%b x=%0d want 0 0", b_flag, xsel);
    end
  endtask

  task automatic test_moves();
    send(8'h22, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    send(8'hB9, 1, 2'b01, 1, 4'd2, 1, 0, 0, 0);
    #1;
    total++;
    if (ysel !== 4'd9 || xsel !== 4'd2) begin
      bad++; $display("FAIL moves_sel: got x=%0d y=%0d want 2 9", xsel, ysel);
    end
    idle();
  endtask

  task automatic test_alt();
    send(8'h3E, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    send(8'h50, 1, 2'b10, 1, 4'd0, 0, 0, 1, 0);
    #1;
    total++;
    if (alt !== 2'd2) begin bad++; $display("FAIL alt_active: got %0d want 2", alt); end
    idle(); #1;
    total++;
    if (alt !== 2'd0) begin bad++; $display("FAIL alt_clear: got %0d want 0", alt); end
    send(8'h3D, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    send(8'h3F, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    #1;
    total++;
    if (alt !== 2'd1) begin bad++; $display("FAIL alt1: got %0d want 1", alt); end
    idle(); #1;
    total++;
    if (alt !== 2'd3) begin bad++; $display("FAIL alt3: got %0d want 3", alt); end
    send(8'h60, 0, 2'b11, 1, 4'd0, 0, 0, 0, 0);
    idle();
  endtask

  task automatic test_hold();
    send(8'h50, 1, 2'b01, 1, 4'd0, 0, 1, 0, 0);
    @(negedge clk);
    hold = 1'b1; op = 8'h16; op_valid = 1'b1; wr_req = 1'b0;
    #1;
    total++;
    if (op_ready !== 1'b0 || enable_l !== 1'b1) begin
      bad++; $display("FAIL hold_pending: got rdy=%b l=%b want 0 1", op_ready, enable_l);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      total++;
      if (op_ready !== 1'b0 || xsel !== 4'd0) begin
        bad++; $display("FAIL hold_freeze1: got rdy=%b x=%0d want 0 0", op_ready, xsel);
      end
    end
    send(8'h16, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    hold = 1'b1; op = 8'h50; op_valid = 1'b1; wr_req = 1'b1; wr_lane = 2'b11;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      total++;
      if (op_ready !== 1'b0) begin bad++; $display("FAIL hold_freeze2: got rdy=%b want 0", op_ready); end
    end
    send(8'h50, 1, 2'b11, 1, 4'd6, 1, 0, 0, 0);
    idle();
  endtask

  task automatic test_back_to_back();
    send(8'h19, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    send(8'h50, 1, 2'b11, 1, 4'd9, 1, 0, 0, 0);
    send(8'h51, 1, 2'b01, 1, 4'd0, 0, 1, 0, 0);
    send(8'h52, 1, 2'b10, 1, 4'd0, 0, 0, 1, 0);
    send(8'h53, 0, 2'b11, 1, 4'd0, 0, 0, 0, 0);
    send(8'h2C, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    send(8'h54, 1, 2'b00, 1, 4'd12, 0, 0, 0, 0);
    idle();
  endtask

  initial begin
    test_reset();
    test_to_from();
    test_move();
    test_moves();
    test_alt();
    test_hold();
    test_back_to_back();
    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL sb_drain: got %0d left want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fig_04b_block_077_reg_prefix_seq.md
Name: fig_04b_block_077_reg_prefix_seq

Overview:
- Register-file write/select sequencer for the GSU core: the driving end of the 16-entry register file port set (xsel, ysel, zsel, enable, enable_l, enable_h, fromset).
- Consumes decoded opcode bytes from fetch and tracks the prefix state (ALT1/2/3, FROM, TO, WITH with its B flag).
- Drives source selects combinationally and a one-cycle-delayed destination write strobe.
- Clears prefix state after every non-prefix instruction, per GSU semantics.

Parameters:
- NREG, 16, register count; selects are log2(NREG)=4 bits wide.
- DEF_REG, 0, value Sreg/Dreg return to after a non-prefix instruction or reset.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- op  in  8  opcode byte from fetch
- op_valid  in  1  op is valid this cycle
- op_ready  out  1  sequencer accepts op this cycle (= ~hold)
- hold  in  1  pipeline stall; freezes prefix state and acceptance
- wr_req  in  1  main decoder: the current non-prefix op writes Dreg
- wr_lane  in  2  bit0 = low byte written, bit1 = high byte written (2'b11 = word)
- xsel  out  4  x source select (= Sreg)
- ysel  out  4  y source select (= Sreg, or Rn for MOVES)
- zsel  out  4  registered destination select
- enable  out  1  registered word write strobe
- enable_l  out  1  registered low-byte write strobe
- enable_h  out  1  registered high-byte write strobe
- fromset  out  1  registered; xbus sources the y path (MOVE)
- alt  out  2  current ALT mode
- b_flag  out  1  WITH flag

Behaviour:
- accept = op_valid & op_ready. No state changes when accept=0; a pending write strobe still fires while hold=1.
- State registers: Sreg[3:0], Dreg[3:0], B, ALT[1:0], plus mode PFX / NORM. PFX is set while any prefix is active.
- Reset: Sreg = Dreg = DEF_REG, B = 0, ALT = 0, mode NORM, and all registered outputs (zsel, enable, enable_l, enable_h, fromset) = 0. Reset mid-operation cancels any pending write.
- Prefix ops (accepted):
  - 0x3D / 0x3E / 0x3F: ALT = 1 / 2 / 3. Sreg, Dreg, B unchanged. Mode PFX.
  - 0x2n WITH: Sreg = Dreg = n, B = 1. ALT unchanged. Mode PFX.
  - 0x1n with B=0 (TO): Dreg = n. Mode PFX.
  - 0xBn with B=0 (FROM): Sreg = n. Mode PFX.
- Move forms (treated as non-prefix; wr_req and wr_lane are ignored, full word write):
  - 0x1n with B=1 (MOVE Rn,Sreg): next cycle zsel = n, enable = 1, fromset = 1. ysel = Sreg during the accept cycle.
  - 0xBn with B=1 (MOVES Dreg,Rn): ysel = n during the accept cycle; next cycle zsel = Dreg, enable = 1, fromset = 0.
- Any other accepted op (non-prefix):
  - Next cycle: zsel = Dreg, and enable / enable_l / enable_h = wr_req & (wr_lane == 3) / wr_req & (wr_lane == 1) / wr_req & (wr_lane == 2).
  - wr_lane = 0 with wr_req = 1 gives no strobe.
- After any non-prefix or move: Sreg = Dreg = DEF_REG, B = 0, ALT = 0, mode NORM, all on the accept edge.
- xsel/ysel are combinational from the state held before the edge, so they are valid in the accept cycle. Latency from accept to write strobe is exactly 1 cycle.
- Strobes are single-cycle pulses and at most one of enable / enable_l / enable_h is high. Back-to-back writes every cycle are supported.
- Chained prefixes (e.g. ALT2, TO R3, FROM R5) accumulate. A later WITH overwrites both Sreg and Dreg.

Decomposition:
- Shared package fig_04b_pkg holds:
  - opcode constants: OP_ALT1 = 8'h3D, OP_ALT2 = 8'h3E, OP_ALT3 = 8'h3F, OP_TO_HI = 4'h1, OP_WITH_HI = 4'h2, OP_FROM_HI = 4'hB;
  - mode enum {NORM, PFX};
  - lane encoding constants LANE_W, LANE_L, LANE_H.
- One sub-module is natural: fig_04b_block_077_wb_stage, the registered zsel/strobe/fromset stage with asynchronous clear.

Test Plan:
- Reset asserted mid-stream with a pending write → enable, enable_l, enable_h, zsel, alt, b_flag all read 0 the same cycle; Sreg = Dreg = 0.
- TO R3, FROM R5, then non-prefix op with wr_req=1, wr_lane=3 → xsel = ysel = 5 in the op cycle; next cycle zsel = 3, enable = 1; then Sreg = Dreg = 0.
- WITH R7, then 0x14 → ysel = 7; next cycle zsel = 4, enable = 1, fromset = 1; b_flag = 0 afterwards.
- WITH R2, then 0xB9 → ysel = 9; next cycle zsel = 2, enable = 1, fromset = 0.
- ALT2, then non-prefix op with wr_lane=2 → alt = 2 during the op cycle; next cycle enable_h = 1, zsel = 0; alt = 0 afterwards.
- hold=1 for 3 cycles with op_valid=1 after a TO R6 → op_ready = 0 and Dreg stays 6; a pending strobe still fires; on release, the op is accepted with zsel = 6.
